// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline control widths, memory-op encodings and the ID/EX control bundle
package core_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 4;
  localparam int EX_W = 8;

  localparam int M_MEMRD_HI = 3;
  localparam int M_MEMRD_LO = 2;

  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } idex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: decoded ID inputs, registered EX outputs, stall/flush
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  import core_pkg::*;

  logic              id_valid_i;
  logic [WB_W-1:0]   wb_i;
  logic [M_W-1:0]    m_i;
  logic [EX_W-1:0]   ex_i;
  logic [DATA_W-1:0] pc4_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_AW-1:0] rs_i;
  logic [REG_AW-1:0] rt_i;
  logic [REG_AW-1:0] rd_i;
  logic              flush_i;

  logic [WB_W-1:0]   wb_o;
  logic [M_W-1:0]    m_o;
  logic [EX_W-1:0]   ex_o;
  logic [DATA_W-1:0] pc4_o;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [REG_AW-1:0] rs_o;
  logic [REG_AW-1:0] rt_o;
  logic [REG_AW-1:0] rd_o;
  logic              ex_valid_o;
  logic              stall_o;
  logic [15:0]       stall_cnt_o;

  modport master (
    output id_valid_i, wb_i, m_i, ex_i, pc4_i, rs_data_i, rt_data_i, imm_i,
           rs_i, rt_i, rd_i, flush_i,
    input  wb_o, m_o, ex_o, pc4_o, rs_data_o, rt_data_o, imm_o,
           rs_o, rt_o, rd_o, ex_valid_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, wb_i, m_i, ex_i, pc4_i, rs_data_i, rt_data_i, imm_i,
           rs_i, rt_i, rd_i, flush_i,
    output wb_o, m_o, ex_o, pc4_o, rs_data_o, rt_data_o, imm_o,
           rs_o, rt_o, rd_o, ex_valid_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard: a load in EX whose rt feeds the ID instruction
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic [1:0]        i_ex_memrd,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_haz
);

  logic w_ex_is_load;
  logic w_rt_match;

  assign w_ex_is_load = i_ex_valid && (i_ex_memrd != 2'b00);
  // rt is compared for every opcode; r0 never carries a dependency.
  assign w_rt_match   = (i_ex_rt != '0) && ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
  assign o_haz        = w_ex_is_load && i_id_valid && w_rt_match;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and branch flush
// Optional stall-cycle counter enabled by IDEX_PERF_CNT_EN.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  idex_ctrl_t        r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  logic w_haz;
  logic w_stall;
  logic w_kill;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .i_ex_valid (r_valid),
    .i_ex_memrd (r_ctrl.m[M_MEMRD_HI:M_MEMRD_LO]),
    .i_ex_rt    (r_rt),
    .i_id_valid (bus.id_valid_i),
    .i_id_rs    (bus.rs_i),
    .i_id_rt    (bus.rt_i),
    .o_haz      (w_haz)
  );

  assign w_stall = w_haz && !bus.flush_i;
  assign w_kill  = bus.flush_i || w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else begin
      // Data fields load unconditionally; ex_valid qualifies them downstream.
      r_pc4     <= bus.pc4_i;
      r_rs_data <= bus.rs_data_i;
      r_rt_data <= bus.rt_data_i;
      r_imm     <= bus.imm_i;
      r_rs      <= bus.rs_i;
      r_rt      <= bus.rt_i;
      r_rd      <= bus.rd_i;
      if (w_kill) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= '{wb: bus.wb_i, m: bus.m_i, ex: bus.ex_i};
        r_valid <= bus.id_valid_i;
      end
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`else
  assign bus.stall_cnt_o = 16'h0000;
`endif

  assign bus.wb_o       = r_ctrl.wb;
  assign bus.m_o        = r_ctrl.m;
  assign bus.ex_o       = r_ctrl.ex;
  assign bus.ex_valid_o = r_valid;
  assign bus.pc4_o      = r_pc4;
  assign bus.rs_data_o  = r_rs_data;
  assign bus.rt_data_o  = r_rt_data;
  assign bus.imm_o      = r_imm;
  assign bus.rs_o       = r_rs;
  assign bus.rt_o       = r_rt;
  assign bus.rd_o       = r_rd;
  assign bus.stall_o    = w_stall;

endmodule
